// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the elevator cabin request scheduler and the
//   downstream motor/door stage (elevator_function).
//   - sched_state_t : scheduler FSM state encoding
//   - DEFAULT_FLOORS / DEFAULT_DOOR_CYCLES : default build parameters
package elevator_pkg;

    localparam int DEFAULT_FLOORS      = 32;
    localparam int DEFAULT_DOOR_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3,
        HALT      = 3'd4
    } sched_state_t;

endpackage

// File: rtl/elevator_req_scan.sv
// elevator_req_scan
//   Purely combinational scan of the pending-request vector against the
//   cabin position.
//   Ports:
//     i_pending  [FLOORS] outstanding requests, bit i = floor i
//     i_position [POS_W]  current/last floor index
//     o_here              request pending at i_position
//     o_above             any request at a floor above i_position
//     o_below             any request at a floor below i_position
//   A position outside 0..FLOORS-1 reports no request anywhere.
module elevator_req_scan #(
    parameter int FLOORS = 32,
    parameter int POS_W  = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0] i_pending,
    input  logic [POS_W-1:0]  i_position,
    output logic              o_here,
    output logic              o_above,
    output logic              o_below
);

    logic [31:0] w_pos_u;
    logic        w_pos_valid;
    logic        w_here;
    logic        w_above;
    logic        w_below;

    assign w_pos_u     = 32'(i_position);
    assign w_pos_valid = (w_pos_u < 32'(FLOORS));

    always_comb begin
        w_here  = 1'b0;
        w_above = 1'b0;
        w_below = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (i_pending[i]) begin
                if (i == w_pos_u)
                    w_here = 1'b1;
                else if (i > w_pos_u)
                    w_above = 1'b1;
                else
                    w_below = 1'b1;
            end
        end
    end

    // An out-of-range position would otherwise see every request as "below".
    assign o_here  = w_here;
    assign o_above = w_above;
    assign o_below = w_below & w_pos_valid;

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Cabin request scheduler: latches hall and cabin presses into a pending
//   vector, picks the next target with a direction-preserving sweep, and
//   drives motor direction and door timing. off_btn performs an orderly stop
//   at the next floor and parks the cabin (HALT).
//   Ports:
//     clock, reset        single clock, synchronous active-high reset
//     off_btn             level, stop service and park
//     position, at_floor  cabin floor index and alignment flag
//     floor_press_event   one-cycle hall-call pulses
//     cabin_press_event   one-cycle cabin-button pulses
//     motor_up/motor_down drive direction (never both set)
//     door                door open
//     dir_up              sweep direction (1 = up)
//     pending             outstanding requests
//     busy                state is not IDLE
//   Build option: define ELEVATOR_SCHED_DOOR_HOLD_EN to let a press for the
//   current floor during DOOR_OPEN restart the door dwell.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS      = DEFAULT_FLOORS,
    parameter int DOOR_CYCLES = DEFAULT_DOOR_CYCLES,
    parameter int POS_W       = $clog2(FLOORS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              off_btn,
    input  logic [POS_W-1:0]  position,
    input  logic              at_floor,
    input  logic [FLOORS-1:0] floor_press_event,
    input  logic [FLOORS-1:0] cabin_press_event,
    output logic              motor_up,
    output logic              motor_down,
    output logic              door,
    output logic              dir_up,
    output logic [FLOORS-1:0] pending,
    output logic              busy
);

    localparam int              TMR_W      = $clog2(DOOR_CYCLES);
    localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(DOOR_CYCLES - 1);

    sched_state_t      r_state;
    logic [FLOORS-1:0] r_pending;
    logic              r_dir_up;
    logic [TMR_W-1:0]  r_timer;

    logic              w_here;
    logic              w_above;
    logic              w_below;
    logic [31:0]       w_pos_u;
    logic [FLOORS-1:0] w_pos_mask;
    logic [FLOORS-1:0] w_press;
    logic [FLOORS-1:0] w_pend_acc;
    logic [FLOORS-1:0] w_pend_open;
    logic              w_at_top;
    logic              w_at_bottom;
    logic              w_hold;

    elevator_req_scan #(
        .FLOORS (FLOORS),
        .POS_W  (POS_W)
    ) u_scan (
        .i_pending  (r_pending),
        .i_position (position),
        .o_here     (w_here),
        .o_above    (w_above),
        .o_below    (w_below)
    );

    assign w_pos_u     = 32'(position);
    assign w_at_top    = (w_pos_u == 32'(FLOORS - 1));
    assign w_at_bottom = (w_pos_u == '0);

    always_comb begin
        w_pos_mask = '0;
        for (int unsigned i = 0; i < FLOORS; i++)
            w_pos_mask[i] = (i == w_pos_u);
    end

    assign w_press     = floor_press_event | cabin_press_event;
    assign w_pend_acc  = r_pending | w_press;
    // Entering or sitting in DOOR_OPEN serves the current floor, so a press
    // for it in the same cycle is absorbed rather than re-queued.
    assign w_pend_open = w_pend_acc & ~w_pos_mask;

`ifdef ELEVATOR_SCHED_DOOR_HOLD_EN
    assign w_hold = |(w_press & w_pos_mask);
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_timer   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pending <= w_pend_acc;
                    if (off_btn) begin
                        r_state   <= HALT;
                        r_pending <= '0;
                    end else if (w_here && at_floor) begin
                        r_state   <= DOOR_OPEN;
                        r_timer   <= TIMER_LOAD;
                        r_pending <= w_pend_open;
                    end else if (w_above && (r_dir_up || !w_below)) begin
                        r_state  <= MOVE_UP;
                        r_dir_up <= 1'b1;
                    end else if (w_below) begin
                        r_state  <= MOVE_DOWN;
                        r_dir_up <= 1'b0;
                    end
                end

                MOVE_UP, MOVE_DOWN: begin
                    r_pending <= w_pend_acc;
                    if (at_floor) begin
                        if (w_here) begin
                            r_state   <= DOOR_OPEN;
                            r_timer   <= TIMER_LOAD;
                            r_pending <= w_pend_open;
                        end else if (off_btn) begin
                            r_state   <= HALT;
                            r_pending <= '0;
                        end else if (r_state == MOVE_UP) begin
                            if (!w_above || w_at_top)
                                r_state <= IDLE;
                        end else begin
                            if (!w_below || w_at_bottom)
                                r_state <= IDLE;
                        end
                    end
                end

                DOOR_OPEN: begin
                    r_pending <= w_pend_open;
                    if (w_hold) begin
                        r_timer <= TIMER_LOAD;
                    end else if (r_timer == '0) begin
                        if (off_btn) begin
                            r_state   <= HALT;
                            r_pending <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                HALT: begin
                    r_pending <= '0;
                    if (!off_btn)
                        r_state <= IDLE;
                end

                default: begin
                    r_state   <= IDLE;
                    r_pending <= '0;
                end
            endcase
        end
    end

    assign motor_up   = (r_state == MOVE_UP);
    assign motor_down = (r_state == MOVE_DOWN);
    assign door       = (r_state == DOOR_OPEN) || ((r_state == HALT) && at_floor);
    assign busy       = (r_state != IDLE);
    assign dir_up     = r_dir_up;
    assign pending    = r_pending;

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler for the elevator cabin. Latches hall (floor) and cabin button presses into a pending-request vector and chooses the next target floor with a direction-preserving sweep. Drives motor direction and door timing to `elevator_function`'s motor and door stage, and handles the off button as an orderly stop.

## Interface
Parameters:
- `FLOORS`, 32: number of floors; one request bit per floor.
- `DOOR_CYCLES`, 8: door-open dwell in clock cycles (≥2).
- `POS_W`, $clog2(FLOORS): width of `position`.

Ports:
- `clock`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `off_btn`  in  1  level; stop service and park.
- `position`  in  POS_W  current/last floor index of the cabin.
- `at_floor`  in  1  cabin aligned with `position` (level).
- `floor_press_event`  in  FLOORS  one-cycle hall-call pulses, bit i = floor i.
- `cabin_press_event`  in  FLOORS  one-cycle cabin-button pulses.
- `motor_up`  out  1  drive cabin up.
- `motor_down`  out  1  drive cabin down.
- `door`  out  1  door open.
- `dir_up`  out  1  sweep direction (1 = up).
- `pending`  out  FLOORS  outstanding requests.
- `busy`  out  1  state ≠ IDLE.

## Operation
- State register values: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, HALT.
- Outputs are Moore-decoded from registered state:
  - `motor_up` = MOVE_UP.
  - `motor_down` = MOVE_DOWN.
  - `door` = DOOR_OPEN, or HALT while `at_floor`.
  - `motor_up` and `motor_down` are never both 1.
- `pending` update each cycle: `pending | floor_press_event | cabin_press_event`, then clear bit `position` on entry to DOOR_OPEN. A press for that floor in the entry cycle is absorbed, not retained.
- Combinational scan against `position`:
  - `here` = `pending[position]`.
  - `above` = any bit > `position`.
  - `below` = any bit < `position`.
- IDLE transitions, in priority order:
  1. `off_btn` → HALT.
  2. `here` & `at_floor` → DOOR_OPEN.
  3. `above` & (`dir_up` | !`below`) → MOVE_UP, `dir_up`←1.
  4. `below` → MOVE_DOWN, `dir_up`←0.
  5. Otherwise stay.
- MOVE_UP / MOVE_DOWN: only evaluated while `at_floor` = 1.
  - `here` → DOOR_OPEN.
  - `off_btn` → HALT.
  - No request further in the current direction, or at end floor (FLOORS-1 up, 0 down) → IDLE.
  - Otherwise continue.
- DOOR_OPEN:
  - Timer loads DOOR_CYCLES-1 on entry and decrements.
  - At 0 → HALT if `off_btn`, else IDLE.
- HALT:
  - Entry clears `pending`; presses are ignored while in HALT.
  - `off_btn`=0 → IDLE.
- `position` ≥ FLOORS is treated as no request here and sets neither `above` nor `below`.

## Timing
- Reset values:
  - State IDLE, `pending`=0, `dir_up`=1, timer=0.
  - `motor_up`=`motor_down`=`door`=0, `busy`=0.
- Press pulse in cycle n → `pending` bit set at n+1.
- Earliest motor assertion is n+2: IDLE decides at n+1, state updates at n+2.
- DOOR_OPEN lasts exactly DOOR_CYCLES cycles, then IDLE for at least one cycle before any motor output.
- Arrival (`at_floor` with `here`) in cycle m: motor output drops at m+1, `door` rises at m+1.
- `reset` mid-operation: all state returns to reset values on the next edge, including the door closing and pending being dropped.

## Configuration
- `ELEVATOR_SCHED_DOOR_HOLD_EN`
  - Defined: a press (either source) for floor `position` while in DOOR_OPEN reloads the timer to DOOR_CYCLES-1 and is not recorded in `pending`.
  - Undefined: such a press is dropped; the timer runs down unchanged.

## Structure
- Package `elevator_pkg` holds:
  - the state enum type;
  - default FLOORS and DOOR_CYCLES constants;
  - a `sched_state_t` typedef shared with `elevator_function`.
- Sub-module `elevator_req_scan`: purely combinational; takes `pending` and `position`, returns `here`, `above`, `below`.
- Timer, FSM and pending register stay in the top module.

## Test plan
All scenarios use FLOORS=8, DOOR_CYCLES=4.
- Reset held 3 cycles, then released: all outputs 0, `dir_up`=1, `pending`=0.
- `position`=2, `at_floor`=1, hall press on floor 5 → `motor_up`=1 two cycles after the press. Step `position` 3,4,5 with `at_floor` → motor drops and `door`=1 for exactly 4 cycles at floor 5; `pending`=0.
- `position`=4 moving up, requests at 6 and 1 → serves 6 first, then IDLE, then MOVE_DOWN to 1; `dir_up` toggles to 0.
- Door open at floor 3, cabin press on 3 at timer=1:
  - with the macro defined → door stays open 4 more cycles;
  - without it → door closes on schedule and `pending[3]` stays 0.
- `off_btn` raised during MOVE_UP between floors → motor continues to the next `at_floor`, then HALT: `door`=1, `pending` cleared, presses ignored. Release `off_btn` → IDLE next cycle.
- Simultaneous floor and cabin press on floor 7 at `position`=0 while `dir_up`=0 → MOVE_UP; `motor_up` and `motor_down` never both 1 for the whole run.
